noc_local_inject_buffer: RTL and testbench

NOC_LOCAL_INJECT_BUFFER -- requirements
Module: noc_local_inject_buffer

---
 rtl/noc_local_inject_buffer.sv | 150 +++++++++++++++
 tb/tb_noc_local_inject_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_inject_buffer.sv
// noc_local_inject_buffer
//   Injection FIFO between a node and its router's local port. Incoming
//   flits pass through a framing FSM: correctly framed flits are stored in
//   a circular buffer, and misframed flits are consumed and dropped. The
//   buffer is first-word-fall-through.
// Ports:
//   noc_clk, noc_rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_flit          node-side handshake and payload
//   in_is_header/in_is_tail            node-side framing markers
//   out_valid/out_ready/out_flit       router-side handshake and payload
//   out_is_header/out_is_tail          head-of-queue framing markers
//   level                              current occupancy
//   pkt_sent                           tail flits delivered (mod 256)
//   proto_err                          sticky framing-violation flag

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FLIT_W = `Noc_Data_Width
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLIT_W-1:0]          in_flit,
    input  logic                       in_is_header,
    input  logic                       in_is_tail,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_is_header,
    output logic                       out_is_tail,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 pkt_sent,
    output logic                       proto_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef struct packed {
        logic              hdr;
        logic              tail;
        logic [FLIT_W-1:0] flit;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } state_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_pkt_sent;
    logic          r_proto_err;
    state_t        r_state;

    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_accept;
    logic   w_store;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    // Handshake: ready/valid derive only from registered occupancy.
    assign w_in_ready  = (r_level != LW'(DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_accept    = in_valid & w_in_ready;
    // IDLE keeps only headers; IN_PKT keeps only non-headers.
    assign w_store     = (r_state == ST_IDLE) ? in_is_header : ~in_is_header;
    assign w_push      = w_accept & w_store;
    assign w_pop       = w_out_valid & out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    // Head entry is masked so an empty buffer presents zeros.
    assign out_flit      = w_out_valid ? w_head.flit : '0;
    assign out_is_header = w_out_valid & w_head.hdr;
    assign out_is_tail   = w_out_valid & w_head.tail;
    assign level         = r_level;
    assign pkt_sent      = r_pkt_sent;
    assign proto_err     = r_proto_err;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge noc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{hdr: in_is_header, tail: in_is_tail, flit: in_flit};
        end
    end

    // Pointers, occupancy and delivered-packet counter; DEPTH is a power of
    // two so pointers wrap naturally.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pkt_sent <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_head.tail) begin
                    r_pkt_sent <= r_pkt_sent + 8'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Input framing FSM with sticky error flag; advances on every consumed flit.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state     <= ST_IDLE;
            r_proto_err <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!in_is_header) begin
                        r_proto_err <= 1'b1;
                    end else if (!in_is_tail) begin
                        r_state <= ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (in_is_header) begin
                        r_proto_err <= 1'b1;
                    end else if (in_is_tail) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_inject_buffer.sv
// Directed bench for noc_local_inject_buffer (DEPTH=8, FLIT_W=32).

module tb_noc_local_inject_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned FLIT_W = 32;

    logic              noc_clk;
    logic              noc_rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit;
    logic              in_is_header;
    logic              in_is_tail;
    logic              out_valid;
    logic              out_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_is_header;
    logic              out_is_tail;
    logic [3:0]        level;
    logic [7:0]        pkt_sent;
    logic              proto_err;

    noc_local_inject_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .noc_clk       (noc_clk),
        .noc_rst_n     (noc_rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_is_header  (in_is_header),
        .in_is_tail    (in_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .level         (level),
        .pkt_sent      (pkt_sent),
        .proto_err     (proto_err)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Drive inputs, take one rising edge, settle past it.
    task automatic step(input logic iv, input logic [31:0] fl, input logic h,
                        input logic t, input logic ordy);
        in_valid     = iv;
        in_flit      = fl;
        in_is_header = h;
        in_is_tail   = t;
        out_ready    = ordy;
        @(posedge noc_clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_flit = '0; in_is_header = 0; in_is_tail = 0; out_ready = 0;
        noc_rst_n = 1'b0;
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] fl;
        logic        h;
        logic        t;
        logic        ordy;
        logic [3:0]  e_level;
        logic        e_ov;
        logic [31:0] e_flit;
        logic        e_h;
        logic        e_t;
        logic [7:0]  e_pkt;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // 3-flit packet streamed with out_ready=1, then H, dup-H, T framing errors.
        vecs[0] = '{1, 32'h0000_00A1, 1, 0, 1, 4'd1, 1, 32'h0000_00A1, 1, 0, 8'd0, 0};
        vecs[1] = '{1, 32'hFFFF_FFFF, 0, 0, 1, 4'd1, 1, 32'hFFFF_FFFF, 0, 0, 8'd0, 0};
        vecs[2] = '{1, 32'h0000_00A3, 0, 1, 1, 4'd1, 1, 32'h0000_00A3, 0, 1, 8'd0, 0};
        vecs[3] = '{0, 32'h0000_0000, 0, 0, 1, 4'd0, 0, 32'h0000_0000, 0, 0, 8'd1, 0};
        vecs[4] = '{1, 32'h0000_00B0, 0, 0, 1, 4'd0, 0, 32'h0000_0000, 0, 0, 8'd1, 1};
        vecs[5] = '{1, 32'h0000_00B1, 1, 0, 1, 4'd1, 1, 32'h0000_00B1, 1, 0, 8'd1, 1};
        vecs[6] = '{1, 32'h0000_00B2, 1, 0, 1, 4'd0, 0, 32'h0000_0000, 0, 0, 8'd1, 1};
        vecs[7] = '{1, 32'h0000_00B3, 0, 1, 1, 4'd1, 1, 32'h0000_00B3, 0, 1, 8'd1, 1};
        vecs[8] = '{0, 32'h0000_0000, 0, 0, 1, 4'd0, 0, 32'h0000_0000, 0, 0, 8'd2, 1};

        in_valid = 0; in_flit = '0; in_is_header = 0; in_is_tail = 0; out_ready = 0;
        noc_rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_level",     32'(level),     32'd0);
        check("rst_out_flit",  out_flit,       32'd0);
        check("rst_pkt_sent",  32'(pkt_sent),  32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].iv, vecs[i].fl, vecs[i].h, vecs[i].t, vecs[i].ordy);
            check($sformatf("v%0d_level", i),     32'(level),         32'(vecs[i].e_level));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid),     32'(vecs[i].e_ov));
            check($sformatf("v%0d_out_flit", i),  out_flit,           vecs[i].e_flit);
            check($sformatf("v%0d_out_hdr", i),   32'(out_is_header), 32'(vecs[i].e_h));
            check($sformatf("v%0d_out_tail", i),  32'(out_is_tail),   32'(vecs[i].e_t));
            check($sformatf("v%0d_pkt_sent", i),  32'(pkt_sent),      32'(vecs[i].e_pkt));
            check($sformatf("v%0d_proto_err", i), 32'(proto_err),     32'(vecs[i].e_err));
        end

        // Fill to full with out_ready=0, refuse a 9th, then drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 32'h100 + 32'(i), (i % 4) == 0, (i % 4) == 3, 0);
            check($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 32'h999, 1, 0, 0);
        step(1, 32'h999, 1, 0, 0);
        check("full_level_hold", 32'(level), 32'd8);
        check("full_head_stable", out_flit, 32'h100);
        for (int i = 0; i < 8; i++) begin
            in_valid = 0;
            out_ready = 1;
            #1;
            check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d_flit", i), out_flit, 32'h100 + 32'(i));
            check($sformatf("drain%0d_hdr", i), 32'(out_is_header), 32'((i % 4) == 0));
            check($sformatf("drain%0d_tail", i), 32'(out_is_tail), 32'((i % 4) == 3));
            step(0, '0, 0, 0, 1);
        end
        check("drain_level", 32'(level), 32'd0);
        check("drain_pkt_sent", 32'(pkt_sent), 32'd2);
        check("drain_in_ready", 32'(in_ready), 32'd1);

        // Steady push+pop at level 4 across pointer wrap.
        do_reset();
        step(1, 32'h200, 1, 0, 0);
        for (int i = 1; i < 4; i++) step(1, 32'h200 + 32'(i), 0, 0, 0);
        check("ss_level_init", 32'(level), 32'd4);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("ss%0d_head", k), out_flit, 32'h200 + 32'(k));
            step(1, 32'h204 + 32'(k), 0, 0, 1);
            check($sformatf("ss%0d_level", k), 32'(level), 32'd4);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ssd%0d_head", k), out_flit, 32'h20A + 32'(k));
            step(0, '0, 0, 0, 1);
        end
        check("ss_empty", 32'(out_valid), 32'd0);

        // 256 single-flit packets: counter wraps, FSM stays IDLE.
        do_reset();
        for (int i = 0; i < 256; i++) step(1, 32'(i), 1, 1, 1);
        check("wrap_pkt_255", 32'(pkt_sent), 32'd255);
        step(0, '0, 0, 0, 1);
        check("wrap_pkt_0", 32'(pkt_sent), 32'd0);
        check("wrap_no_err", 32'(proto_err), 32'd0);
        step(1, 32'h55, 0, 0, 1);
        check("wrap_idle_drop_level", 32'(level), 32'd0);
        check("wrap_idle_drop_err", 32'(proto_err), 32'd1);

        // Reset mid-packet discards storage; data flit afterwards is misframed.
        do_reset();
        step(1, 32'h300, 1, 0, 0);
        step(1, 32'h301, 0, 0, 0);
        check("mid_level_pre", 32'(level), 32'd2);
        in_valid = 0;
        #2;
        noc_rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_flit", out_flit, 32'd0);
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        step(1, 32'h302, 0, 0, 1);
        check("post_rst_level", 32'(level), 32'd0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_err", 32'(proto_err), 32'd1);
        step(0, '0, 0, 0, 1);
        check("post_rst_err_sticky", 32'(proto_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
